// File: rtl/fetch_instr_queue.sv
// Fetch-to-decode decoupling queue: a circular buffer of {instr, pc, pc+4} triples
// that absorbs decode stalls, drops everything on redirect and shows a NOP when empty.
module fetch_instr_queue #(
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     ILEN      = 32,
    parameter int unsigned     XLEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_in,
    input  logic [ILEN-1:0]            instr_in,
    input  logic [XLEN-1:0]            pc_in,
    input  logic [XLEN-1:0]            pc_plus4_in,
    input  logic                       flush_in,
    input  logic                       stall_in,
    output logic                       full_out,
    output logic                       valid_out,
    output logic [ILEN-1:0]            instr_out,
    output logic [XLEN-1:0]            pc_out,
    output logic [XLEN-1:0]            pc_plus4_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [ILEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] pc4_mem_q   [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic push;
    logic pop;

    // A full queue refuses pushes even when a pop frees a slot in the same cycle.
    assign full_out  = (count_q == CW'(DEPTH));
    assign valid_out = (count_q != '0);
    assign push      = valid_in  & ~full_out & ~flush_in;
    assign pop       = valid_out & ~stall_in & ~flush_in;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; only pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= instr_in;
            pc_mem_q[wr_ptr_q]    <= pc_in;
            pc4_mem_q[wr_ptr_q]   <= pc_plus4_in;
        end
    end

    assign instr_out    = valid_out ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
    assign pc_out       = valid_out ? pc_mem_q[rd_ptr_q]    : '0;
    assign pc_plus4_out = valid_out ? pc4_mem_q[rd_ptr_q]   : '0;
    assign count_out    = count_q;

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Directed bench for fetch_instr_queue: the driver records accepted triples in an
// expected queue, and a negedge monitor compares the head and status outputs.
module tb_fetch_instr_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic [31:0] pc_plus4_in;
    logic        flush_in;
    logic        stall_in;
    logic        full_out;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic [2:0]  count_out;

    logic [95:0] exp_q[$];
    int          m_count;
    int          checks;
    int          failures;
    logic        mon_en;
    int          emitted;

    fetch_instr_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .instr_in     (instr_in),
        .pc_in        (pc_in),
        .pc_plus4_in  (pc_plus4_in),
        .flush_in     (flush_in),
        .stall_in     (stall_in),
        .full_out     (full_out),
        .valid_out    (valid_out),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .pc_plus4_out (pc_plus4_out),
        .count_out    (count_out)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // driver: one cycle of stimulus, then the reference queue update at the edge
    task automatic step(input logic v, input logic [31:0] pc, input logic st,
                        input logic fl, input logic rst_n);
        logic do_push;
        logic do_pop;
        valid_in    = v;
        pc_in       = pc;
        instr_in    = instr_of(pc);
        pc_plus4_in = pc + 32'd4;
        stall_in    = st;
        flush_in    = fl;
        reset       = rst_n;
        @(posedge clk);
        if (!rst_n || fl) begin
            m_count = 0;
            exp_q.delete();
        end else begin
            do_pop  = (m_count != 0) && !st;
            do_push = v && (m_count != DEPTH);
            if (do_push) exp_q.push_back({instr_of(pc), pc, pc + 32'd4});
            m_count = m_count + int'(do_push) - int'(do_pop);
        end
        #1;
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, st, 1'b0, 1'b1);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [95:0] head;
        if (mon_en) begin
            check("count_out", 32'(count_out), 32'(m_count));
            check("valid_out", 32'(valid_out), 32'(m_count != 0));
            check("full_out",  32'(full_out),  32'(m_count == DEPTH));
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_entry: got pc %h expected none", pc_out);
                end else begin
                    head = exp_q[0];
                    check("instr_out",    instr_out,    head[95:64]);
                    check("pc_out",       pc_out,       head[63:32]);
                    check("pc_plus4_out", pc_plus4_out, head[31:0]);
                    if (!stall_in && !flush_in && reset) begin
                        void'(exp_q.pop_front());
                        emitted++;
                    end
                end
            end else begin
                check("empty_instr", instr_out,    NOP);
                check("empty_pc",    pc_out,       32'h0);
                check("empty_pc4",   pc_plus4_out, 32'h0);
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        m_count  = 0;
        emitted  = 0;
        mon_en   = 1'b0;
        valid_in = 1'b0; instr_in = '0; pc_in = '0; pc_plus4_in = '0;
        stall_in = 1'b0; flush_in = 1'b0; reset = 1'b0;

        // 1: reset, three pushes with decode flowing
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        idle(1, 1'b0);
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h4, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h8, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        check("t1_emitted", 32'(emitted), 32'd3);

        // 2: fill while stalled, fifth push refused, then drain
        for (int i = 0; i < 5; i++) step(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b1);
        check("t2_full", 32'(full_out), 32'd1);
        idle(5, 1'b0);
        check("t2_emitted", 32'(emitted), 32'd7);

        // 3: full with simultaneous push and pop, push refused then accepted
        for (int i = 0; i < 4; i++) step(1'b1, 32'h20 + 32'(i * 4), 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h30, 1'b0, 1'b0, 1'b1);
        check("t3_count_after_pop", 32'(count_out), 32'd3);
        step(1'b1, 32'h30, 1'b1, 1'b0, 1'b1);
        check("t3_count_after_push", 32'(count_out), 32'd4);
        idle(5, 1'b0);

        // 4: flush at count 2 drops the same-cycle fetch
        step(1'b1, 32'h50, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h54, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
        check("t4_count", 32'(count_out), 32'd0);
        check("t4_nop", instr_out, NOP);
        idle(2, 1'b0);

        // 5: steady push/pop at count 1 across pointer wrap
        emitted = 0;
        step(1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) step(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        check("t5_emitted", 32'(emitted), 32'd11);

        // 6: reset mid-operation at count 3, then restart
        for (int i = 0; i < 3; i++) step(1'b1, 32'h80 + 32'(i * 4), 1'b1, 1'b0, 1'b1);
        check("t6_count_before", 32'(count_out), 32'd3);
        step(1'b1, 32'h8C, 1'b1, 1'b0, 1'b0);
        check("t6_count_reset", 32'(count_out), 32'd0);
        check("t6_pc_reset", pc_out, 32'h0);
        step(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        check("t6_pc_restart", pc_out, 32'h200);
        idle(2, 1'b0);

        mon_en = 1'b0;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
